mux16_rr_arbiter: RTL and testbench

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

---
 rtl/mux16_arb_pkg.sv | 20 ++
 rtl/rr_pick16.sv | 26 ++
 rtl/mux16_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 16-way
// round-robin arbiter.
package mux16_arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// wrapping modulo 16.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand_s;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    idx    = ptr;
    found  = 1'b0;
    cand_s = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = ptr + k[SEL_W-1:0];
      idx    = req[cand_s] ? cand_s : idx;
      found  = found | req[cand_s];
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter producing grant and select for an external shared
// 16:1 mux; each grant is bounded to MAX_HOLD cycles with a mandatory bubble.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       hold_q, hold_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic             release_s;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Next-state logic; sel_q doubles as the owner index while in GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    release_s = done | ~req[sel_q] | (hold_q == HOLD_LAST);
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = GRANT;
          sel_d   = pick_idx_s;
          gnt_d   = onehot16(pick_idx_s);
          valid_d = 1'b1;
          hold_d  = 4'd0;
        end else begin
          gnt_d   = {N_REQ{1'b0}};
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d = IDLE;
          gnt_d   = {N_REQ{1'b0}};
          valid_d = 1'b0;
          ptr_d   = sel_q + 4'd1;
          hold_d  = 4'd0;
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N_REQ{1'b0}};
        valid_d = 1'b0;
        hold_d  = 4'd0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      hold_q  <= 4'd0;
      sel_q   <= 4'd0;
      gnt_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus a
// randomized run against a behavioural owner/pointer model.
module tb_mux16_rr_arbiter;

  localparam int MAXH = 8;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        valid;

  int chk;
  int pass;

  // Behavioural model: who owns the path, how long, and where the scan starts.
  int m_owner;
  int m_ptr;
  int m_last;
  int m_held;

  mux16_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_held  = 0;
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      for (int k = 0; k < 16; k++) begin
        int c;
        c = (m_ptr + k) % 16;
        if (req[c]) begin
          m_owner = c;
          m_held  = 1;
          break;
        end
      end
    end else if (done || !req[m_owner] || m_held == MAXH) begin
      m_ptr   = (m_owner + 1) % 16;
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [20:0] model_out();
    logic [15:0] g;
    logic [3:0]  s;
    g = 16'h0000;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      s = 4'(m_owner);
    end else begin
      s = 4'(m_last);
    end
    return {g, s, (m_owner >= 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    model_reset();
    #1;
    chk++;
    if ({gnt, sel, valid} !== 21'h0) $display("FAIL reset_async got=%h exp=%h", {gnt, sel, valid}, 21'h0);
    else pass++;
    req = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk++;
    if ({gnt, sel, valid} !== 21'h0) $display("FAIL reset_held got=%h exp=%h", {gnt, sel, valid}, 21'h0);
    else pass++;
    req = 16'h0000;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0001;
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h0001, 4'd0, 1'b1}) $display("FAIL single_grant got=%h exp=%h", {gnt, sel, valid}, {16'h0001, 4'd0, 1'b1});
    else pass++;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk++;
    if ({gnt, valid} !== {16'h0000, 1'b0}) $display("FAIL single_release got=%h exp=%h", {gnt, valid}, 17'h0);
    else pass++;
    req = 16'h0000;
    tick();
  endtask

  task automatic test_fairness();
    logic [15:0] fseq [8];
    fseq = '{16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000};
    do_reset();
    req  = 16'h8001;
    done = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk++;
      if (gnt !== fseq[c]) $display("FAIL fairness_c%0d got=%h exp=%h", c, gnt, fseq[c]);
      else pass++;
    end
    done = 1'b0;
    req  = 16'h0000;
    tick();
  endtask

  task automatic test_timeout();
    logic [15:0] eg;
    do_reset();
    req  = 16'h0010;
    done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      eg = (c == 9) ? 16'h0000 : 16'h0010;
      chk++;
      if ({gnt, sel, valid} !== {eg, 4'd4, (c != 9)}) $display("FAIL timeout_c%0d got=%h exp=%h", c, {gnt, sel, valid}, {eg, 4'd4, (c != 9)});
      else pass++;
    end
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h8000;
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h8000, 4'd15, 1'b1}) $display("FAIL wrap_own15 got=%h exp=%h", {gnt, sel, valid}, {16'h8000, 4'd15, 1'b1});
    else pass++;
    req = 16'h0003;
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h0000, 4'd15, 1'b0}) $display("FAIL wrap_bubble got=%h exp=%h", {gnt, sel, valid}, {16'h0000, 4'd15, 1'b0});
    else pass++;
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h0001, 4'd0, 1'b1}) $display("FAIL wrap_next got=%h exp=%h", {gnt, sel, valid}, {16'h0001, 4'd0, 1'b1});
    else pass++;
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 16'h0080;
    tick();
    req = 16'h0101;
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h0000, 4'd7, 1'b0}) $display("FAIL drop_release got=%h exp=%h", {gnt, sel, valid}, {16'h0000, 4'd7, 1'b0});
    else pass++;
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h0100, 4'd8, 1'b1}) $display("FAIL drop_next got=%h exp=%h", {gnt, sel, valid}, {16'h0100, 4'd8, 1'b1});
    else pass++;
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    req  = 16'h0060;
    done = 1'b1;
    tick();
    tick();
    tick();
    chk++;
    if (gnt !== 16'h0040) $display("FAIL midrst_pre got=%h exp=%h", gnt, 16'h0040);
    else pass++;
    rst = 1'b1;
    #1;
    chk++;
    if ({gnt, sel, valid} !== 21'h0) $display("FAIL midrst_async got=%h exp=%h", {gnt, sel, valid}, 21'h0);
    else pass++;
    rst  = 1'b0;
    done = 1'b0;
    model_reset();
    tick();
    chk++;
    if ({gnt, sel, valid} !== {16'h0020, 4'd5, 1'b1}) $display("FAIL midrst_resume got=%h exp=%h", {gnt, sel, valid}, {16'h0020, 4'd5, 1'b1});
    else pass++;
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    req  = 16'h0000;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
      done = ($urandom_range(0, 5) == 0);
      if (c % 150 == 149) begin
        do_reset();
        chk++;
        if ({gnt, sel, valid} !== 21'h0) $display("FAIL rand_reset c=%0d got=%h exp=%h", c, {gnt, sel, valid}, 21'h0);
        else pass++;
      end else begin
        tick();
        chk++;
        if ({gnt, sel, valid} !== model_out()) $display("FAIL rand_model c=%0d got=%h exp=%h", c, {gnt, sel, valid}, model_out());
        else pass++;
        chk++;
        if ($countones(gnt) > 1) $display("FAIL rand_onehot c=%0d got=%h exp=at_most_one", c, gnt);
        else pass++;
      end
    end
    req  = 16'h0000;
    done = 1'b0;
  endtask

  initial begin
    chk  = 0;
    pass = 0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_wrap();
    test_owner_drop();
    test_reset_midgrant();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
